step_out_ctrl: RTL and testbench
================================

Name: step_out_ctrl

Overview:
- Parametrised N-axis stepper output stage between the motion core's per-axis step/dir/enable strobes and the board pins.
- Replaces the fixed four-axis direct pin assignment.
- Enforces minimum step high/low times and direction setup time, queues steps that arrive while an axis is busy, and applies per-axis output polarity.
- One instance drives all axes; step, dir and enable pins are registered outputs.

Parameters:
- N_AXES, 4, number of axes (1..16).
- STEP_HIGH, 50, step pulse high time in osc_clk cycles (>=1).
- STEP_LOW, 50, minimum step low time after a pulse, in cycles (>=1).
- DIR_SETUP, 100, cycles from a dir pin change to the next step rising edge (>=1).
- PEND_W, 4, width of the per-axis pending-step counter; max pending = 2^PEND_W-1.
- STEP_INV, {N_AXES{1'b0}}, per-axis step pin inversion mask.
- DIR_INV, {N_AXES{1'b0}}, per-axis dir pin inversion mask.
- EN_INV, {N_AXES{1'b0}}, per-axis enable pin inversion mask.

Ports:
- osc_clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- step_req  in  N_AXES  single-cycle step strobe per axis.
- dir_req  in  N_AXES  requested direction per axis; sampled when a step is started.
- enable_req  in  N_AXES  axis enable, level.
- ovf_clr  in  1  clears all overflow flags.
- motor_step  out  N_AXES  step pins, after STEP_INV.
- motor_dir  out  N_AXES  dir pins, after DIR_INV.
- motor_enable  out  N_AXES  enable pins, after EN_INV.
- busy  out  N_AXES  axis FSM not IDLE, or pending count nonzero.
- overflow  out  N_AXES  sticky: a step was dropped because the queue was full.

Behaviour:
- Clock and reset: osc_clk is the only clock. rst is asynchronous and active-high.
- Reset values:
  - All FSMs IDLE, pending = 0, applied dir = 0, overflow = 0, busy = 0.
  - motor_step = STEP_INV, motor_dir = DIR_INV, motor_enable = EN_INV (all inactive).
- Output registers: pin = internal level XOR mask bit. Pins change one cycle after the internal decision.
- motor_enable[i] = enable_req[i] XOR EN_INV[i], registered, 1-cycle latency.
- Per-axis FSM: IDLE, SETUP, HIGH, LOW, with a down-counter sized for the largest of STEP_HIGH, STEP_LOW, DIR_SETUP.
- IDLE: a start occurs when enable_req = 1 and (step_req = 1 or pending > 0).
  - At start, dir_req is sampled.
  - If it equals the applied dir, go to HIGH; motor_step rises the next cycle.
  - Otherwise update the applied dir (motor_dir changes the next cycle) and go to SETUP.
- SETUP: lasts DIR_SETUP cycles with step low, then HIGH.
- HIGH: step held high exactly STEP_HIGH cycles, then LOW.
- LOW: step held low STEP_LOW cycles, then IDLE.
  - Back-to-back pending steps therefore repeat every STEP_HIGH+STEP_LOW+1 cycles (the IDLE decision cycle included).
- Queueing: step_req while not IDLE, or while pending is being served, increments pending.
  - A start consuming from pending decrements it.
  - step_req and consume in the same cycle: pending unchanged; the new request is effectively queued.
  - A step_req accepted directly in IDLE with pending = 0 does not touch pending.
- Queue full: step_req with pending = max and no consume in that cycle drops the request and sets overflow[i].
- Overflow clear: ovf_clr clears overflow the next cycle. If a set and ovf_clr occur in the same cycle, set wins.
- Queued steps use dir_req as sampled at their own start. Upstream holds dir_req stable until busy drops before reversing.
- enable_req = 0:
  - New step_req is ignored (no overflow).
  - pending is cleared.
  - A pulse in SETUP/HIGH/LOW completes normally; the FSM then stays IDLE.
- Axes are fully independent. Simultaneous events on different axes do not interact.
- Reset mid-pulse: step drops to its inactive level asynchronously, and all queues are lost.

Test Plan:
- Defaults, axis 0 enabled, dir_req = 0, one step_req at cycle 10 -> motor_step[0] high cycles 11..60, low from 61, busy low at 112.
- dir_req[1] = 1 plus step_req -> motor_dir[1] toggles the next cycle; step rises exactly 100 cycles later; width 50.
- 5 step_req strobes on axis 2 within 20 cycles -> 5 pulses, 101-cycle period, pending returns to 0, no overflow.
- PEND_W = 2: 5 strobes during one pulse -> 3 queued, 1 dropped, overflow[3] = 1. ovf_clr pulse -> 0. A set in the same cycle as ovf_clr -> stays 1.
- STEP_INV = 4'b0001, EN_INV = 4'b1111: after reset motor_step[0] = 1 and motor_enable = 4'hF. A pulse drives motor_step[0] low for 50 cycles.
- enable_req drop mid-HIGH with 3 pending -> current pulse completes, pending cleared, no further pulses. rst asserted mid-pulse -> all outputs at reset values immediately.

Source files
------------

// File: rtl/step_out_ctrl.sv
// N-axis stepper output stage: enforces step high/low and dir setup timing,
// queues steps that arrive while an axis is busy, and applies pin polarity.
module step_out_ctrl #(
  parameter int unsigned        N_AXES    = 4,
  parameter int unsigned        STEP_HIGH = 50,
  parameter int unsigned        STEP_LOW  = 50,
  parameter int unsigned        DIR_SETUP = 100,
  parameter int unsigned        PEND_W    = 4,
  parameter logic [N_AXES-1:0]  STEP_INV  = '0,
  parameter logic [N_AXES-1:0]  DIR_INV   = '0,
  parameter logic [N_AXES-1:0]  EN_INV    = '0
) (
  input  logic              osc_clk,
  input  logic              rst,
  input  logic [N_AXES-1:0] step_req,
  input  logic [N_AXES-1:0] dir_req,
  input  logic [N_AXES-1:0] enable_req,
  input  logic              ovf_clr,
  output logic [N_AXES-1:0] motor_step,
  output logic [N_AXES-1:0] motor_dir,
  output logic [N_AXES-1:0] motor_enable,
  output logic [N_AXES-1:0] busy,
  output logic [N_AXES-1:0] overflow
);

  localparam int unsigned MAX_HL = (STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW;
  localparam int unsigned MAX_T  = (MAX_HL > DIR_SETUP) ? MAX_HL : DIR_SETUP;
  localparam int unsigned CNT_W  = $clog2(MAX_T + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  state_t            state_q [N_AXES];
  state_t            state_d [N_AXES];
  logic [CNT_W-1:0]  cnt_q   [N_AXES];
  logic [CNT_W-1:0]  cnt_d   [N_AXES];
  logic [PEND_W-1:0] pend_q  [N_AXES];
  logic [PEND_W-1:0] pend_d  [N_AXES];
  logic [N_AXES-1:0] dir_q, dir_d;
  logic [N_AXES-1:0] ovf_q, ovf_d;
  logic [N_AXES-1:0] step_pin_q, step_pin_d;
  logic [N_AXES-1:0] dir_pin_q, dir_pin_d;
  logic [N_AXES-1:0] en_pin_q, en_pin_d;
  logic [N_AXES-1:0] busy_q, busy_d;
  logic [N_AXES-1:0] consume_c, queue_c, drop_c;

  // Per-axis FSM, pending queue and overflow next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    dir_d      = dir_q;
    ovf_d      = ovf_q;
    consume_c  = '0;
    queue_c    = '0;
    drop_c     = '0;
    step_pin_d = '0;
    busy_d     = '0;
    for (int i = 0; i < N_AXES; i++) begin
      case (state_q[i])
        S_IDLE: begin
          if (enable_req[i] && (step_req[i] || pend_q[i] != '0)) begin
            consume_c[i] = (pend_q[i] != '0);
            if (dir_req[i] == dir_q[i]) begin
              state_d[i] = S_HIGH;
              cnt_d[i]   = CNT_W'(STEP_HIGH - 1);
            end else begin
              dir_d[i]   = dir_req[i];
              state_d[i] = S_SETUP;
              cnt_d[i]   = CNT_W'(DIR_SETUP - 1);
            end
          end
        end
        S_SETUP: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = CNT_W'(STEP_HIGH - 1);
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = CNT_W'(STEP_LOW - 1);
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        S_LOW: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = S_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: state_d[i] = S_IDLE;
      endcase

      // A request only bypasses the queue when it starts straight from an empty IDLE
      queue_c[i] = step_req[i] && enable_req[i] &&
                   (state_q[i] != S_IDLE || pend_q[i] != '0);
      if (!enable_req[i]) begin
        pend_d[i] = '0;
      end else if (queue_c[i] && !consume_c[i]) begin
        if (pend_q[i] == PEND_MAX) drop_c[i] = 1'b1;
        else                       pend_d[i] = pend_q[i] + PEND_W'(1);
      end else if (!queue_c[i] && consume_c[i]) begin
        pend_d[i] = pend_q[i] - PEND_W'(1);
      end

      ovf_d[i]      = drop_c[i] | (ovf_q[i] & ~ovf_clr);
      step_pin_d[i] = (state_d[i] == S_HIGH) ^ STEP_INV[i];
      busy_d[i]     = (state_q[i] != S_IDLE) || (pend_q[i] != '0);
    end
    dir_pin_d = dir_d ^ DIR_INV;
    en_pin_d  = enable_req ^ EN_INV;
  end

  always_ff @(posedge osc_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_AXES; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
      dir_q      <= '0;
      ovf_q      <= '0;
      step_pin_q <= STEP_INV;
      dir_pin_q  <= DIR_INV;
      en_pin_q   <= EN_INV;
      busy_q     <= '0;
    end else begin
      for (int i = 0; i < N_AXES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
      dir_q      <= dir_d;
      ovf_q      <= ovf_d;
      step_pin_q <= step_pin_d;
      dir_pin_q  <= dir_pin_d;
      en_pin_q   <= en_pin_d;
      busy_q     <= busy_d;
    end
  end

  assign motor_step   = step_pin_q;
  assign motor_dir    = dir_pin_q;
  assign motor_enable = en_pin_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_step_out_ctrl.sv
// Scoreboard bench for step_out_ctrl: expected step pin edges are queued by the
// stimulus and popped by an edge monitor; level checks cover dir/enable/busy/overflow.
module tb_step_out_ctrl;

  localparam logic [3:0] STEP_INV = 4'b0001;
  localparam logic [3:0] EN_INV   = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] step_req, dir_req, enable_req;
  logic       ovf_clr;
  logic [3:0] motor_step, motor_dir, motor_enable, busy, overflow;

  step_out_ctrl #(
    .N_AXES(4), .STEP_HIGH(50), .STEP_LOW(50), .DIR_SETUP(100), .PEND_W(2),
    .STEP_INV(STEP_INV), .DIR_INV(4'b0000), .EN_INV(EN_INV)
  ) dut (
    .osc_clk(clk), .rst(rst), .step_req(step_req), .dir_req(dir_req),
    .enable_req(enable_req), .ovf_clr(ovf_clr), .motor_step(motor_step),
    .motor_dir(motor_dir), .motor_enable(motor_enable), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   axis;
    logic lvl;
    int   cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev = 4'b0001;
  int         base;

  always @(posedge clk) cyc <= cyc + 1;

  // Step-pin edge monitor: every edge must match the head of the expected queue
  always @(negedge clk) begin
    for (int a = 0; a < 4; a++) begin
      if (mon_en && motor_step[a] !== prev[a]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL step_edge: unexpected edge axis %0d level %0b at cycle %0d", a, motor_step[a], cyc);
        end else begin
          ev = exp_q.pop_front();
          if (ev.axis != a || ev.lvl !== motor_step[a] || ev.cyc != cyc) begin
            n_bad++;
            $display("FAIL step_edge: got axis %0d level %0b cycle %0d, want axis %0d level %0b cycle %0d",
                     a, motor_step[a], cyc, ev.axis, ev.lvl, ev.cyc);
          end
        end
      end
    end
    prev = motor_step;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic strobe(input int c, input logic [3:0] m);
    at(c);
    step_req = m;
    @(negedge clk);
    step_req = 4'b0000;
  endtask

  task automatic push_ev(input int a, input logic l, input int c);
    ev_t e;
    e.axis = a; e.lvl = l; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // One pulse: active level at rise, inactive 50 cycles later
  task automatic push_pulse(input int a, input int rise);
    push_ev(a, ~STEP_INV[a], rise);
    push_ev(a, STEP_INV[a], rise + 50);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; step_req = '0; dir_req = '0; enable_req = '0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_step", 32'(motor_step), 32'(4'b0001));
    chk("rst_dir", 32'(motor_dir), 32'(4'b0000));
    chk("rst_en", 32'(motor_enable), 32'(4'b1111));
    chk("rst_busy", 32'(busy), 32'(4'b0000));
    chk("rst_ovf", 32'(overflow), 32'(4'b0000));
    rst = 1'b0;
    enable_req = 4'hF;
    @(negedge clk);
    chk("en_on", 32'(motor_enable), 32'(4'b0000));
    mon_en = 1'b1;

    // Axis 0 single step, same dir
    base = cyc + 10;
    push_pulse(0, base + 1);
    strobe(base, 4'b0001);
    at(base + 101); chk("t1_busy_hi", 32'(busy[0]), 32'd1);
    at(base + 102); chk("t1_busy_lo", 32'(busy[0]), 32'd0);

    // Axis 1 with direction change: setup delay before the pulse
    base = cyc + 10;
    dir_req = 4'b0010;
    at(base); chk("t2_dir_before", 32'(motor_dir), 32'(4'b0000));
    push_pulse(1, base + 101);
    strobe(base, 4'b0010);
    chk("t2_dir_after", 32'(motor_dir), 32'(4'b0010));
    at(base + 202); chk("t2_busy_lo", 32'(busy[1]), 32'd0);

    // Axis 2: four strobes, queue fills exactly, 101-cycle period
    base = cyc + 10;
    for (int k = 0; k < 4; k++) push_pulse(2, base + 1 + 101 * k);
    for (int k = 0; k < 4; k++) strobe(base + 5 * k, 4'b0100);
    at(base + 404); chk("t3_busy_hi", 32'(busy[2]), 32'd1);
    at(base + 405); chk("t3_busy_lo", 32'(busy[2]), 32'd0);
    chk("t3_no_ovf", 32'(overflow), 32'(4'b0000));

    // Axis 3: overflow, clear, and set-wins-over-clear
    base = cyc + 10;
    for (int k = 0; k < 4; k++) push_pulse(3, base + 1 + 101 * k);
    for (int k = 0; k < 4; k++) strobe(base + 2 * k, 4'b1000);
    at(base + 8); chk("t4_ovf_pre", 32'(overflow[3]), 32'd0);
    strobe(base + 8, 4'b1000);
    chk("t4_ovf_set", 32'(overflow[3]), 32'd1);
    at(base + 12); ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow[3]), 32'd0);
    at(base + 15); step_req = 4'b1000; ovf_clr = 1'b1;
    @(negedge clk); step_req = '0; ovf_clr = 1'b0;
    chk("t4_set_wins", 32'(overflow[3]), 32'd1);
    at(base + 405); chk("t4_busy_lo", 32'(busy[3]), 32'd0);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    chk("t4_ovf_clr2", 32'(overflow), 32'(4'b0000));

    // Axis 0 (inverted pin): enable dropped mid-HIGH with 3 pending
    base = cyc + 10;
    push_pulse(0, base + 1);
    for (int k = 0; k < 4; k++) strobe(base + 2 * k, 4'b0001);
    at(base + 20); enable_req = 4'b1110;
    @(negedge clk);
    chk("t5_en_pin", 32'(motor_enable), 32'(4'b0001));
    strobe(base + 30, 4'b0001);
    at(base + 101); chk("t5_busy_hi", 32'(busy[0]), 32'd1);
    at(base + 102); chk("t5_busy_lo", 32'(busy[0]), 32'd0);
    strobe(base + 110, 4'b0001);
    at(base + 120); enable_req = 4'hF;
    at(base + 250);
    chk("t5_ovf", 32'(overflow), 32'(4'b0000));
    chk("t5_busy", 32'(busy), 32'(4'b0000));

    // Reset mid-pulse on axes 1 and 2, with a queued step on axis 2
    base = cyc + 10;
    push_ev(1, 1'b1, base + 1);
    push_ev(2, 1'b1, base + 1);
    push_ev(1, 1'b0, base + 10);
    push_ev(2, 1'b0, base + 10);
    strobe(base, 4'b0110);
    strobe(base + 3, 4'b0100);
    at(base + 9);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_step", 32'(motor_step), 32'(4'b0001));
    chk("t6_dir", 32'(motor_dir), 32'(4'b0000));
    chk("t6_en", 32'(motor_enable), 32'(4'b1111));
    chk("t6_busy", 32'(busy), 32'(4'b0000));
    at(base + 13); rst = 1'b0;
    at(base + 200);
    chk("t6_busy_after", 32'(busy), 32'(4'b0000));
    chk("t6_en_after", 32'(motor_enable), 32'(4'b0000));

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
